adc128s022_responder: RTL and testbench

//   Synthesizable SPI responder that emulates the ADC128S022 8-ch 12-bit ADC on the DE0-Nano ADC nets.

---
 rtl/adc128s022_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_adc128s022_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc128s022_responder.sv
// adc128s022_responder: SPI responder emulating the ADC128S022 8-channel 12-bit ADC.
// SCLK, CS_N and SADDR are oversampled in the CLOCK_50 domain; each 16-bit frame returns
// the channel register addressed in the previous frame of the same CS-low burst.
// Optional feature macro: ADC_RESP_AUTOINC_EN -- when defined, the channel just shifted
// out increments by 1 on every completed frame (ramp pattern); cfg writes win.
module adc128s022_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [11:0] RESET_BASE  = 12'h000,
    parameter logic [11:0] RESET_STEP  = 12'h200
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        ADC_SCLK,
    input  logic        ADC_CS_N,
    input  logic        ADC_SADDR,
    output logic        ADC_SDAT,
    output logic        sdat_oe,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [11:0] cfg_data,
    output logic [2:0]  cur_chan,
    output logic        addr_strobe,
    output logic [2:0]  addr_out,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        IDLE    = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    // Channel n reset code: (RESET_BASE + n*RESET_STEP) mod 4096, wrap is natural at 12 bits.
    function automatic logic [11:0] reset_code(input int n);
        return RESET_BASE + (RESET_STEP * 12'(n));
    endfunction

    // Synchronizer chains; vld_sync marks which stages hold post-reset pin samples so the
    // reset values of the chain are never mistaken for a real bus level.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] saddr_sync;
    logic [SYNC_STAGES-1:0] vld_sync;
    logic                   sclk_d;
    logic                   cs_d;

    logic sclk_s, cs_s, saddr_s, sync_ok;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    // Channel registers
    logic [11:0] chan_reg [8];

    // FSM and datapath registers with their next-state values
    state_t      state, state_n;
    logic [15:0] shreg, shreg_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [2:0]  addr_sh, addr_sh_n;
    logic [2:0]  pending, pending_n;
    logic [2:0]  cur_chan_n;
    logic        sdat_n, sdat_oe_n;
    logic        addr_strobe_n;
    logic [2:0]  addr_out_n;
    logic        frame_done_n, frame_err_n;
    logic [15:0] frame_cnt_n;

    // Input synchronizers plus one delayed copy of SCLK/CS_N for edge detection
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sclk_sync  <= '1;
            cs_sync    <= '1;
            saddr_sync <= '0;
            vld_sync   <= '0;
            sclk_d     <= 1'b1;
            cs_d       <= 1'b1;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
            saddr_sync <= {saddr_sync[SYNC_STAGES-2:0], ADC_SADDR};
            vld_sync   <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_d     <= sclk_sync[SYNC_STAGES-1];
            cs_d       <= cs_sync[SYNC_STAGES-1];
        end
    end

    // Edge detection on the synchronized bus
    always_comb begin
        sclk_s    = sclk_sync[SYNC_STAGES-1];
        cs_s      = cs_sync[SYNC_STAGES-1];
        saddr_s   = saddr_sync[SYNC_STAGES-1];
        sync_ok   = vld_sync[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_d;
        sclk_fall = ~sclk_s & sclk_d;
        cs_rise   = cs_s & ~cs_d;
        cs_fall   = ~cs_s & cs_d;
    end

    // Next-state and output logic; CS_N edges take priority over SCLK edges
    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        bit_cnt_n     = bit_cnt;
        addr_sh_n     = addr_sh;
        pending_n     = pending;
        cur_chan_n    = cur_chan;
        sdat_n        = ADC_SDAT;
        sdat_oe_n     = sdat_oe;
        addr_strobe_n = 1'b0;
        addr_out_n    = addr_out;
        frame_done_n  = 1'b0;
        frame_err_n   = 1'b0;
        frame_cnt_n   = frame_cnt;

        case (state)
            WAIT_HI: begin
                if (sync_ok && cs_s) begin
                    state_n = IDLE;
                end
            end

            IDLE: begin
                if (cs_fall) begin
                    state_n    = SHIFT;
                    pending_n  = 3'd0;
                    shreg_n    = {4'b0000, chan_reg[0]};
                    cur_chan_n = 3'd0;
                    sdat_oe_n  = 1'b1;
                    sdat_n     = shreg_n[15];
                    bit_cnt_n  = 4'd0;
                end
            end

            SHIFT: begin
                if (cs_rise) begin
                    state_n     = IDLE;
                    sdat_oe_n   = 1'b0;
                    sdat_n      = 1'b0;
                    frame_err_n = (bit_cnt != 4'd0);
                end else if (sclk_rise) begin
                    bit_cnt_n = bit_cnt + 4'd1;
                    // rises 3..5 carry ADD2..ADD0, MSB first
                    if (bit_cnt >= 4'd2 && bit_cnt <= 4'd4) begin
                        addr_sh_n = {addr_sh[1:0], saddr_s};
                    end
                    if (bit_cnt == 4'd15) begin
                        frame_done_n  = 1'b1;
                        frame_cnt_n   = frame_cnt + 16'd1;
                        addr_strobe_n = 1'b1;
                        addr_out_n    = addr_sh;
                        pending_n     = addr_sh;
                    end
                end else if (sclk_fall) begin
                    // counter at zero on a fall marks a frame boundary: reload instead of shift
                    if (bit_cnt == 4'd0) begin
                        shreg_n    = {4'b0000, chan_reg[pending]};
                        cur_chan_n = pending;
                    end else begin
                        shreg_n = {shreg[14:0], 1'b0};
                    end
                    sdat_n = shreg_n[15];
                end
            end

            default: begin
                state_n = WAIT_HI;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= WAIT_HI;
            shreg       <= '0;
            bit_cnt     <= '0;
            addr_sh     <= '0;
            pending     <= '0;
            cur_chan    <= '0;
            ADC_SDAT    <= 1'b0;
            sdat_oe     <= 1'b0;
            addr_strobe <= 1'b0;
            addr_out    <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            addr_sh     <= addr_sh_n;
            pending     <= pending_n;
            cur_chan    <= cur_chan_n;
            ADC_SDAT    <= sdat_n;
            sdat_oe     <= sdat_oe_n;
            addr_strobe <= addr_strobe_n;
            addr_out    <= addr_out_n;
            frame_done  <= frame_done_n;
            frame_err   <= frame_err_n;
            frame_cnt   <= frame_cnt_n;
        end
    end

    // Channel registers: cfg write wins; a same-cycle shift-register load sees the old value
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                chan_reg[i] <= reset_code(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (cfg_we && cfg_addr == 3'(i)) begin
                    chan_reg[i] <= cfg_data;
                end
`ifdef ADC_RESP_AUTOINC_EN
                else if (frame_done_n && cur_chan == 3'(i)) begin
                    chan_reg[i] <= chan_reg[i] + 12'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_adc128s022_responder.sv
// Testbench for adc128s022_responder: table-driven bursts, hand-written corner cases
// and randomized bursts checked against a behavioural channel/frame model.
module tb_adc128s022_responder;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        ADC_SCLK = 1'b1;
    logic        ADC_CS_N = 1'b1;
    logic        ADC_SADDR = 1'b0;
    logic        ADC_SDAT;
    logic        sdat_oe;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [11:0] cfg_data = 12'd0;
    logic [2:0]  cur_chan;
    logic        addr_strobe;
    logic [2:0]  addr_out;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;

    adc128s022_responder dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .ADC_SCLK   (ADC_SCLK),
        .ADC_CS_N   (ADC_CS_N),
        .ADC_SADDR  (ADC_SADDR),
        .ADC_SDAT   (ADC_SDAT),
        .sdat_oe    (sdat_oe),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cur_chan   (cur_chan),
        .addr_strobe(addr_strobe),
        .addr_out   (addr_out),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int failures = 0;

    // pulse counters observed away from the active edge
    int n_done = 0;
    int n_err = 0;
    int n_strobe = 0;
    logic [2:0] last_addr = 3'd0;

    always @(negedge CLOCK_50) begin
        if (frame_done) n_done++;
        if (frame_err) n_err++;
        if (addr_strobe) begin
            n_strobe++;
            last_addr = addr_out;
        end
    end

    // behavioural model: channel contents and completed-frame count
    logic [11:0] m_reg [8];
    logic [15:0] m_cnt;

    // burst buffers
    logic [2:0]  b_addr [8];
    logic [15:0] b_rd [8];
    logic [2:0]  b_chan [8];

    typedef struct {
        int              nfr;
        logic [3:0][2:0] addr;
        logic [3:0][15:0] rd;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 8; n++) m_reg[n] = 12'((n * 512) % 4096);
        m_cnt = 16'd0;
    endtask

    task automatic apply_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        repeat (8) @(negedge CLOCK_50);
    endtask

    task automatic cs_drive(input logic v);
        ADC_CS_N = v;
        repeat (8) @(negedge CLOCK_50);
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [11:0] d);
        @(negedge CLOCK_50);
        cfg_we = 1'b1;
        cfg_addr = ch;
        cfg_data = d;
        @(negedge CLOCK_50);
        cfg_we = 1'b0;
        m_reg[ch] = d;
    endtask

    // one 16-SCLK frame; MISO is sampled just before each rising edge
    task automatic xfer(input logic [2:0] a, output logic [15:0] d, output logic [2:0] ch);
        d = '0;
        ch = '0;
        for (int k = 1; k <= 16; k++) begin
            ADC_SCLK = 1'b0;
            if (k >= 3 && k <= 5) ADC_SADDR = a[5-k];
            else ADC_SADDR = 1'b0;
            repeat (8) @(negedge CLOCK_50);
            d = {d[14:0], ADC_SDAT};
            if (k == 8) ch = cur_chan;
            ADC_SCLK = 1'b1;
            repeat (8) @(negedge CLOCK_50);
        end
    endtask

    task automatic clocks(input int n);
        for (int k = 0; k < n; k++) begin
            ADC_SCLK = 1'b0;
            ADC_SADDR = 1'b0;
            repeat (8) @(negedge CLOCK_50);
            ADC_SCLK = 1'b1;
            repeat (8) @(negedge CLOCK_50);
        end
    endtask

    // CS-low burst of nfr frames, each read compared to the model
    task automatic do_burst(input int nfr);
        logic [2:0]  prev;
        logic [15:0] d;
        logic [2:0]  ch;
        prev = 3'd0;
        cs_drive(1'b0);
        chk("sdat_oe_on", 32'(sdat_oe), 32'd1);
        for (int f = 0; f < nfr; f++) begin
            xfer(b_addr[f], d, ch);
            b_rd[f] = d;
            b_chan[f] = ch;
            chk("rd_model", 32'(d), {20'd0, m_reg[prev]});
            chk("cur_chan", 32'(ch), 32'(prev));
            m_cnt = m_cnt + 16'd1;
`ifdef ADC_RESP_AUTOINC_EN
            m_reg[prev] = m_reg[prev] + 12'd1;
`endif
            prev = b_addr[f];
        end
        cs_drive(1'b1);
        chk("sdat_oe_off", 32'(sdat_oe), 32'd0);
        chk("sdat_idle", 32'(ADC_SDAT), 32'd0);
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    endtask

    initial begin
        int d0, e0, s0;
        vecs[0] = '{nfr: 2, addr: {3'd0, 3'd0, 3'd0, 3'd3},
                    rd: {16'h0000, 16'h0000, 16'h0600, 16'h0000}};
        vecs[1] = '{nfr: 3, addr: {3'd0, 3'd0, 3'd7, 3'd2},
                    rd: {16'h0000, 16'h0E00, 16'h0400, 16'h0000}};
        vecs[2] = '{nfr: 4, addr: {3'd5, 3'd6, 3'd4, 3'd1},
                    rd: {16'h0C00, 16'h0800, 16'h0200, 16'h0000}};
        vecs[3] = '{nfr: 2, addr: {3'd0, 3'd0, 3'd7, 3'd7},
                    rd: {16'h0000, 16'h0000, 16'h0E00, 16'h0000}};

        model_reset();
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (8) @(negedge CLOCK_50);

        // reset state
        chk("rst_sdat", 32'(ADC_SDAT), 32'd0);
        chk("rst_oe", 32'(sdat_oe), 32'd0);
        chk("rst_chan", 32'(cur_chan), 32'd0);
        chk("rst_strobe", 32'(addr_strobe), 32'd0);
        chk("rst_addr_out", 32'(addr_out), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);

        // table-driven bursts, each from a fresh reset
        for (int v = 0; v < 4; v++) begin
            apply_reset();
            d0 = n_done;
            s0 = n_strobe;
            for (int f = 0; f < vecs[v].nfr; f++) b_addr[f] = vecs[v].addr[f];
            do_burst(vecs[v].nfr);
            for (int f = 0; f < vecs[v].nfr; f++) chk("tbl_rd", 32'(b_rd[f]), 32'(vecs[v].rd[f]));
            chk("tbl_cnt", 32'(frame_cnt), 32'(vecs[v].nfr));
            chk("tbl_done", 32'(n_done - d0), 32'(vecs[v].nfr));
            chk("tbl_strobe", 32'(n_strobe - s0), 32'(vecs[v].nfr));
            chk("tbl_addr_out", 32'(last_addr), 32'(vecs[v].addr[vecs[v].nfr-1]));
        end

        // cfg write then read back in the second frame
        apply_reset();
        cfg_write(3'd5, 12'hABC);
        b_addr[0] = 3'd5;
        b_addr[1] = 3'd0;
        do_burst(2);
        chk("cfg_rd", 32'(b_rd[1]), 32'h0ABC);
        chk("cfg_chan", 32'(b_chan[1]), 32'd5);

        // aborted frame after 9 SCLK
        d0 = n_done;
        e0 = n_err;
        cs_drive(1'b0);
        clocks(9);
        cs_drive(1'b1);
        chk("abort_err", 32'(n_err - e0), 32'd1);
        chk("abort_done", 32'(n_done - d0), 32'd0);
        chk("abort_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("abort_oe", 32'(sdat_oe), 32'd0);
        b_addr[0] = 3'd0;
        do_burst(1);
        chk("abort_next", 32'(b_rd[0]), {20'd0, m_reg[0]});

        // reset mid-frame with CS_N held low
        cs_drive(1'b0);
        clocks(6);
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        chk("midrst_oe", 32'(sdat_oe), 32'd0);
        chk("midrst_sdat", 32'(ADC_SDAT), 32'd0);
        chk("midrst_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        d0 = n_done;
        s0 = n_strobe;
        clocks(10);
        chk("midrst_ignored_oe", 32'(sdat_oe), 32'd0);
        chk("midrst_ignored_done", 32'(n_done - d0), 32'd0);
        chk("midrst_ignored_strobe", 32'(n_strobe - s0), 32'd0);
        cs_drive(1'b1);
        b_addr[0] = 3'd0;
        do_burst(1);
        chk("midrst_next", 32'(b_rd[0]), 32'h0000);

        // five frames at address 0
        apply_reset();
        for (int f = 0; f < 5; f++) b_addr[f] = 3'd0;
        do_burst(5);
        for (int f = 0; f < 5; f++) begin
`ifdef ADC_RESP_AUTOINC_EN
            chk("ramp_rd", 32'(b_rd[f]), 32'(f));
`else
            chk("ramp_rd", 32'(b_rd[f]), 32'd0);
`endif
        end

        // randomized bursts and cfg writes against the model
        for (int r = 0; r < 16; r++) begin
            int nfr;
            if ($urandom_range(1, 0) == 1)
                cfg_write(3'($urandom_range(7, 0)), 12'($urandom_range(4095, 0)));
            nfr = $urandom_range(3, 1);
            for (int f = 0; f < nfr; f++) b_addr[f] = 3'($urandom_range(7, 0));
            d0 = n_done;
            do_burst(nfr);
            chk("rnd_done", 32'(n_done - d0), 32'(nfr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
